// File: rtl/oh_event_capture.sv
// oh_event_capture: sticky ao311 event capture with interrupt, overflow count and a valid/ready clear handshake
module oh_event_capture #(
    parameter int DW = 8,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] a0,
    input  logic [DW-1:0] a1,
    input  logic [DW-1:0] a2,
    input  logic [DW-1:0] b0,
    input  logic [DW-1:0] c0,
    input  logic          clr_valid,
    input  logic [DW-1:0] clr_mask,
    output logic          clr_ready,
    output logic [DW-1:0] status,
    output logic          irq,
    output logic [CW-1:0] ovf_count,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE, PEND, ACK} state_t;
    state_t        state_q, state_d;
    logic [DW-1:0] status_q, status_d, hit, clr_eff, ovf_bits;
    logic [CW-1:0] ovf_q, ovf_d;
    logic          irq_q, accept;
    assign clr_ready = state_q != ACK;
    assign busy      = state_q == ACK;
    assign status    = status_q;
    assign irq       = irq_q;
    assign ovf_count = ovf_q;
    // Next-state: event qualification, clear merge (new hits win), overflow counting and FSM
    always_comb begin
        hit      = (a0 & a1 & a2) | b0 | c0;
        accept   = clr_valid & clr_ready;
        clr_eff  = accept ? clr_mask : '0;
        status_d = (status_q & ~clr_eff) | hit;
        ovf_bits = hit & status_q & ~clr_eff;
        ovf_d    = (accept && (&clr_mask)) ? {{(CW-1){1'b0}}, |ovf_bits} :
                   (|ovf_bits && ovf_q != '1) ? ovf_q + 1'b1 : ovf_q;
        state_d  = (state_q != ACK && accept) ? ACK : (|status_d) ? PEND : IDLE;
    end
    // State registers; irq tracks next-state status so it moves on the same edge as status
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            status_q <= '0;
            ovf_q    <= '0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            ovf_q    <= ovf_d;
            irq_q    <= |status_d;
        end
    end
endmodule

// File: tb/tb_oh_event_capture.sv
// tb_oh_event_capture: directed stimulus with a queued-expectation scoreboard for oh_event_capture
module tb_oh_event_capture;
    logic       clk = 1'b0, reset = 1'b1;
    logic [7:0] a0 = '0, a1 = '0, a2 = '0, b0 = '0, c0 = '0, clr_mask = '0;
    logic       clr_valid = 1'b0;
    logic       clr_ready, irq, busy;
    logic [7:0] status;
    logic [3:0] ovf_count;
    int         cyc = 0, n_cmp = 0, n_bad = 0;

    typedef struct {
        int         cyc;
        string      nm;
        logic [7:0] s;
        logic       i;
        logic [3:0] o;
        logic       r;
        logic       b;
    } exp_t;
    exp_t q[$];

    oh_event_capture #(.DW(8), .CW(4)) dut (
        .clk(clk), .reset(reset), .a0(a0), .a1(a1), .a2(a2), .b0(b0), .c0(c0),
        .clr_valid(clr_valid), .clr_mask(clr_mask), .clr_ready(clr_ready),
        .status(status), .irq(irq), .ovf_count(ovf_count), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input exp_t e);
        n_cmp++;
        if ({status, irq, ovf_count, clr_ready, busy} !== {e.s, e.i, e.o, e.r, e.b}) begin
            n_bad++;
            $display("FAIL %s: got status=%h irq=%b ovf=%0d ready=%b busy=%b, want status=%h irq=%b ovf=%0d ready=%b busy=%b",
                     e.nm, status, irq, ovf_count, clr_ready, busy, e.s, e.i, e.o, e.r, e.b);
        end
    endtask

    // Monitor: compare every expectation whose target cycle has arrived
    always @(negedge clk) begin
        while (q.size() != 0 && q[0].cyc <= cyc) chk(q.pop_front());
    end

    task automatic step(input logic [7:0] va0, va1, va2, vb0, vc0, input logic cv, input logic [7:0] cm,
                        input string nm, input logic [7:0] es, input logic ei, input logic [3:0] eo,
                        input logic er, input logic eb);
        @(posedge clk);
        #1;
        a0 = va0; a1 = va1; a2 = va2; b0 = vb0; c0 = vc0; clr_valid = cv; clr_mask = cm;
        q.push_back('{cyc + 1, nm, es, ei, eo, er, eb});
    endtask

    task automatic idle(input string nm, input logic [7:0] es, input logic ei, input logic [3:0] eo,
                        input logic er, input logic eb);
        step(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, nm, es, ei, eo, er, eb);
    endtask

    initial begin
        #2;
        chk('{0, "reset_async", 8'h00, 1'b0, 4'd0, 1'b1, 1'b0});
        @(posedge clk);
        #1 reset = 1'b0;
        for (int k = 0; k < 10; k++) idle("reset_idle", 8'h00, 1'b0, 4'd0, 1'b1, 1'b0);
        step(8'h05, 8'hFF, 8'h04, 8'h00, 8'h00, 1'b0, 8'h00, "and_mask", 8'h04, 1'b1, 4'd0, 1'b1, 1'b0);
        step(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 8'h04, "clr04_ack", 8'h00, 1'b0, 4'd0, 1'b0, 1'b1);
        idle("clr04_idle", 8'h00, 1'b0, 4'd0, 1'b1, 1'b0);
        step(8'h00, 8'h00, 8'h00, 8'h80, 8'h00, 1'b0, 8'h00, "b0_80", 8'h80, 1'b1, 4'd0, 1'b1, 1'b0);
        step(8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 1'b0, 8'h00, "c0_01", 8'h81, 1'b1, 4'd0, 1'b1, 1'b0);
        step(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 8'h80, "clr80_ack", 8'h01, 1'b1, 4'd0, 1'b0, 1'b1);
        idle("clr80_pend", 8'h01, 1'b1, 4'd0, 1'b1, 1'b0);
        step(8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 1'b1, 8'h01, "hit_wins_clr", 8'h01, 1'b1, 4'd0, 1'b0, 1'b1);
        idle("hit_wins_pend", 8'h01, 1'b1, 4'd0, 1'b1, 1'b0);
        step(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 8'h01, "clr01_ack", 8'h00, 1'b0, 4'd0, 1'b0, 1'b1);
        idle("clr01_idle", 8'h00, 1'b0, 4'd0, 1'b1, 1'b0);
        for (int k = 1; k <= 20; k++)
            step(8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 1'b0, 8'h00, "ovf_sat", 8'h02, 1'b1,
                 4'((k - 1) > 15 ? 15 : (k - 1)), 1'b1, 1'b0);
        step(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 8'hFF, "clrff_ack", 8'h00, 1'b0, 4'd0, 1'b0, 1'b1);
        idle("clrff_idle", 8'h00, 1'b0, 4'd0, 1'b1, 1'b0);
        step(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 8'h00, "idle_clr_ack", 8'h00, 1'b0, 4'd0, 1'b0, 1'b1);
        idle("idle_clr_idle", 8'h00, 1'b0, 4'd0, 1'b1, 1'b0);
        step(8'h00, 8'h00, 8'h00, 8'h3C, 8'h00, 1'b0, 8'h00, "b0_3c", 8'h3C, 1'b1, 4'd0, 1'b1, 1'b0);
        step(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 8'h00, "noop_clr_ack", 8'h3C, 1'b1, 4'd0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        clr_valid = 1'b0;
        @(negedge clk);
        #1 reset = 1'b1;
        #1 chk('{0, "reset_in_ack", 8'h00, 1'b0, 4'd0, 1'b1, 1'b0});
        @(posedge clk);
        #1 reset = 1'b0;
        idle("post_reset", 8'h00, 1'b0, 4'd0, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d unchecked expectations, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish by 100000, want finish");
        $fatal(1);
    end
endmodule

// File: doc/oh_event_capture.md
Name: oh_event_capture

Overview:
- Sequential consumer-side counterpart to the stdlib ao311 combinational gate.
- Each bit evaluates the ao311 term hit[i] = (a0&a1&a2)|b0|c0 every cycle and latches it into a sticky status register.
- Raises an interrupt while any status bit is pending.
- A consumer acknowledges and clears bits through a valid/ready clear handshake.
- Placed between ao311-style event qualification logic (source & enable & mask, plus two forced sources) and an interrupt/CSR consumer.

Parameters:
- DW, 8, number of independent event bits.
- CW, 4, width of the saturating overflow counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- a0  input  DW  AND term input 0 (event source).
- a1  input  DW  AND term input 1 (enable).
- a2  input  DW  AND term input 2 (mask, 1 = unmasked).
- b0  input  DW  OR term (forced event 0).
- c0  input  DW  OR term (forced event 1).
- clr_valid  input  1  clear request valid.
- clr_mask  input  DW  bits to clear when the request is accepted.
- clr_ready  output  1  block can accept a clear this cycle.
- status  output  DW  sticky pending-event bits (registered).
- irq  output  1  registered; equals |status.
- ovf_count  output  CW  saturating count of events lost to already-set bits.
- busy  output  1  high in state ACK.

Behaviour:
- Reset (async assert, sync-safe deassert by integrator):
  - status = 0, irq = 0, ovf_count = 0, state = IDLE, clr_ready = 1, busy = 0.
  - Reset mid-operation discards all pending bits and any in-flight clear.
- hit = (a0&a1&a2)|b0|c0, combinational, per bit, no gating by state.
- Capture latency: hit[i] high in cycle N -> status[i] = 1 and irq = 1 from cycle N+1.
- irq is registered from next-state status, so irq and status change on the same edge.
- Clear acceptance:
  - accept = clr_valid & clr_ready.
  - On accept: status_next = (status & ~clr_mask) | hit.
  - A new event on a bit being cleared in the same cycle wins; the bit stays 1.
  - Without accept: status_next = status | hit.
- Overflow: ovf_inc = number of bits i with hit[i] & status[i] & ~(accept & clr_mask[i]).
  - If ovf_inc != 0, ovf_count increments by 1 per cycle, not per bit, saturating at 2^CW-1.
  - An accepted clear with clr_mask all ones also zeroes ovf_count.
  - If that same-cycle ovf_inc != 0, ovf_count = 1.
- State machine:
  - IDLE: status == 0. Go to PEND when status_next != 0.
  - PEND: status != 0. On accept, go to ACK. Otherwise stay.
  - ACK: one cycle. busy = 1, clr_ready = 0. Next state is PEND if status != 0, else IDLE.
  - clr_ready = (state != ACK). A clear request held across ACK is accepted on the following cycle.
  - Accept in IDLE is legal: it clears nothing, and the FSM goes to ACK then IDLE.
- Events are captured in every state, including ACK.
- clr_valid with clr_mask = 0 is a legal no-op clear and still passes through ACK.

Test Plan:
- Reset, then idle inputs -> status = 0x00, irq = 0, ovf_count = 0, clr_ready = 1 held for 10 cycles.
- a0 = 0x05, a1 = 0xFF, a2 = 0x04 for one cycle (DW = 8) -> next cycle status = 0x04, irq = 1. Bit 0 stays clear because it is masked.
- b0 = 0x80 pulse, then c0 = 0x01 pulse -> status = 0x81.
  - clr_valid with clr_mask = 0x80 -> next cycle status = 0x01, busy = 1, clr_ready = 0.
  - Following cycle state is PEND, clr_ready = 1.
- status = 0x01 and b0 = 0x01 in the same cycle as an accepted clear_mask = 0x01 -> status stays 0x01, ovf_count unchanged.
- Hold b0 = 0x02 for 20 cycles (CW = 4) -> status = 0x02, ovf_count saturates at 15.
  - Clear with clr_mask = 0xFF and no hit -> status = 0x00, ovf_count = 0, irq = 0, FSM goes ACK -> IDLE.
- Assert reset asynchronously while in ACK with status = 0x3C -> outputs go to reset values immediately, without waiting for a clock edge.
